// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter.
// One transaction at a time: IDLE -> ACCESS (one-cycle strobe) -> WAIT (latency
// countdown, read data captured on the last WAIT edge) -> RESP (Ack pulse).
module mem_arbiter #(
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        ReqA,
    input  logic        ReqB,
    input  logic        WeA,
    input  logic        WeB,
    input  logic [31:0] AddrA,
    input  logic [31:0] AddrB,
    input  logic [31:0] WDataA,
    input  logic [31:0] WDataB,
    output logic        AckA,
    output logic        AckB,
    output logic [31:0] RDataA,
    output logic [31:0] RDataB,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    input  logic [31:0] MemReadData,
    output logic        Busy,
    output logic        GrantB
);

    localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic        r_owner;       // owner of current/last transaction (1 = B)
    logic        r_last_grant;  // round-robin pointer (1 = B granted last)
    logic [3:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_a;
    logic [31:0] r_rdata_b;

    logic        w_any_req;
    logic        w_winner_b;
    logic        w_wait_done;

    // Round-robin choice: on contention the requester not granted last wins.
    always_comb begin
        w_any_req   = ReqA | ReqB;
        w_winner_b  = (ReqA & ReqB) ? ~r_last_grant : ReqB;
        w_wait_done = (r_count == 4'd1);
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        MemoryRead   = 1'b0;
        MemoryWrite  = 1'b0;
        AckA         = 1'b0;
        AckB         = 1'b0;
        Busy         = 1'b1;
        case (r_state)
            IDLE: begin
                Busy = 1'b0;
                if (w_any_req) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                MemoryRead   = ~r_we;
                MemoryWrite  = r_we;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (w_wait_done) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                AckA         = ~r_owner;
                AckB         = r_owner;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request latch, latency counter and per-requester read data capture.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_we         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_count      <= 4'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_rdata_a    <= 32'd0;
            r_rdata_b    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_winner_b;
                        r_last_grant <= w_winner_b;
                        r_we         <= w_winner_b ? WeB    : WeA;
                        r_addr       <= w_winner_b ? AddrB  : AddrA;
                        r_wdata      <= w_winner_b ? WDataB : WDataA;
                    end
                end
                ACCESS: begin
                    r_count <= r_we ? WR_LAT : RD_LAT;
                end
                WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (w_wait_done && !r_we) begin
                        if (r_owner) begin
                            r_rdata_b <= MemReadData;
                        end else begin
                            r_rdata_a <= MemReadData;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign MemAddress   = r_addr;
    assign MemWriteData = r_wdata;
    assign RDataA       = r_rdata_a;
    assign RDataB       = r_rdata_b;
    assign GrantB       = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a default-latency instance plus a
// READ_LATENCY = 4 instance sharing the request inputs and a small memory.
module tb_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        ReqA, ReqB, WeA, WeB;
    logic [31:0] AddrA, AddrB, WDataA, WDataB;

    logic        AckA, AckB, MemoryRead, MemoryWrite, Busy, GrantB;
    logic [31:0] RDataA, RDataB, MemAddress, MemWriteData, MemReadData;

    logic        AckA4, AckB4, MemoryRead4, MemoryWrite4, Busy4, GrantB4;
    logic [31:0] RDataA4, RDataB4, MemAddress4, MemWriteData4, MemReadData4;

    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [31:0] pre_data = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        b;
        logic        rd;
        logic [31:0] data;
        int          ack_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 Clock = ~Clock;

    mem_arbiter dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
        .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
        .AckA(AckA), .AckB(AckB), .RDataA(RDataA), .RDataB(RDataB),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
        .MemReadData(MemReadData), .Busy(Busy), .GrantB(GrantB)
    );

    mem_arbiter #(.READ_LATENCY(4), .WRITE_LATENCY(1)) dut4 (
        .Clock(Clock), .Reset_n(Reset_n),
        .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
        .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
        .AckA(AckA4), .AckB(AckB4), .RDataA(RDataA4), .RDataB(RDataB4),
        .MemAddress(MemAddress4), .MemWriteData(MemWriteData4),
        .MemoryRead(MemoryRead4), .MemoryWrite(MemoryWrite4),
        .MemReadData(MemReadData4), .Busy(Busy4), .GrantB(GrantB4)
    );

    // Memory model: only the default instance writes; both read combinationally.
    always @(posedge Clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (MemoryWrite) mem[MemAddress[7:0]] <= MemWriteData;
    end
    assign MemReadData  = mem[MemAddress[7:0]];
    assign MemReadData4 = mem[MemAddress4[7:0]];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    // Single transaction on the default instance, started from IDLE.
    task automatic run_txn(input logic b, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
        exp_t e, g;
        bit   done;
        e.b = b; e.rd = !we; e.data = exp_rd; e.ack_cyc = we ? 3 : 4;
        sb.push_back(e);
        if (b) begin ReqB = 1'b1; WeB = we; AddrB = addr; WDataB = wdata; end
        else   begin ReqA = 1'b1; WeA = we; AddrA = addr; WDataA = wdata; end
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            step();
            if (c == 1) begin
                chk("strobe_rd_c1", {31'd0, MemoryRead}, {31'd0, !we});
                chk("strobe_wr_c1", {31'd0, MemoryWrite}, {31'd0, we});
                chk("mem_addr", MemAddress, addr);
                if (we) chk("mem_wdata", MemWriteData, wdata);
            end
            if (c == 2) chk("strobes_c2", {30'd0, MemoryRead, MemoryWrite}, 32'd0);
            if (AckA || AckB) begin
                g = sb.pop_front();
                done = 1'b1;
                chk("ack_excl", {31'd0, AckA & AckB}, 32'd0);
                chk("ack_owner", {31'd0, AckB}, {31'd0, g.b});
                chk("ack_cycle", c, g.ack_cyc);
                chk("grantb", {31'd0, GrantB}, {31'd0, g.b});
                if (g.rd) chk("rdata", g.b ? RDataB : RDataA, g.data);
            end
        end
        if (!done) chk("ack_timeout", 32'd0, 32'd1);
        ReqA = 1'b0; ReqB = 1'b0;
        step();
    endtask

    initial begin
        exp_t e, g;
        int   acks;
        bit   saw_ack;
        Reset_n = 1'b0;
        ReqA = 1'b0; ReqB = 1'b0; WeA = 1'b0; WeB = 1'b0;
        AddrA = 32'd0; AddrB = 32'd0; WDataA = 32'd0; WDataB = 32'd0;
        step();
        preload(8'd5, 32'hDEADBEEF);
        preload(8'd1, 32'h11111111);
        preload(8'd2, 32'h22222222);

        // Reset state
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_grantb", {31'd0, GrantB}, 32'd0);
        chk("rst_addr", MemAddress, 32'd0);
        chk("rst_wdata", MemWriteData, 32'd0);
        chk("rst_rdata_a", RDataA, 32'd0);
        chk("rst_rdata_b", RDataB, 32'd0);
        chk("rst_strobes_acks", {28'd0, MemoryRead, MemoryWrite, AckA, AckB}, 32'd0);

        Reset_n = 1'b1;
        run_txn(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF);
        chk("rdata_b_untouched", RDataB, 32'd0);
        run_txn(1'b1, 1'b1, 32'd9, 32'h12345678, 32'd0);
        run_txn(1'b1, 1'b0, 32'd9, 32'd0, 32'h12345678);
        chk("rdata_a_hold1", RDataA, 32'hDEADBEEF);
        chk("idle_addr_hold", MemAddress, 32'd9);
        run_txn(1'b0, 1'b1, 32'd3, 32'h0000A5A5, 32'd0);
        run_txn(1'b1, 1'b0, 32'd3, 32'd0, 32'h0000A5A5);
        chk("rdata_a_hold2", RDataA, 32'hDEADBEEF);

        // Contention from reset release: A, B, A, B
        Reset_n = 1'b0;
        step();
        ReqA = 1'b1; WeA = 1'b0; AddrA = 32'd1;
        ReqB = 1'b1; WeB = 1'b0; AddrB = 32'd2;
        for (int i = 0; i < 4; i++) begin
            e.b = i[0]; e.rd = 1'b1; e.ack_cyc = 0;
            e.data = i[0] ? 32'h22222222 : 32'h11111111;
            sb.push_back(e);
        end
        Reset_n = 1'b1;
        acks = 0;
        for (int c = 1; c <= 60 && acks < 4; c++) begin
            step();
            if (MemoryRead && MemoryWrite) chk("rr_strobe_excl", 32'd1, 32'd0);
            if (AckA || AckB) begin
                g = sb.pop_front();
                acks++;
                chk("rr_ack_excl", {31'd0, AckA & AckB}, 32'd0);
                chk("rr_owner", {31'd0, AckB}, {31'd0, g.b});
                chk("rr_grantb", {31'd0, GrantB}, {31'd0, g.b});
                chk("rr_rdata", g.b ? RDataB : RDataA, g.data);
            end
        end
        chk("rr_ack_count", acks, 32'd4);
        ReqA = 1'b0; ReqB = 1'b0;
        sb.delete();
        step();
        step();

        // Reset during WAIT of an A read
        ReqA = 1'b1; WeA = 1'b0; AddrA = 32'd5;
        step();
        step();
        chk("abort_in_wait", {31'd0, Busy}, 32'd1);
        Reset_n = 1'b0;
        step();
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_rdata_a", RDataA, 32'd0);
        chk("abort_strobes_ack", {29'd0, MemoryRead, MemoryWrite, AckA}, 32'd0);
        Reset_n = 1'b1; ReqA = 1'b0;
        saw_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (AckA) saw_ack = 1'b1;
        end
        chk("abort_no_ack", {31'd0, saw_ack}, 32'd0);

        // READ_LATENCY = 4 instance: Ack in cycle 6, address held during WAIT
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        ReqA = 1'b1; WeA = 1'b0; AddrA = 32'd5;
        step();
        chk("l4_strobe_c1", {31'd0, MemoryRead4}, 32'd1);
        step();
        AddrA = 32'd7;
        saw_ack = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            step();
            if (c < 6) begin
                chk("l4_addr_hold", MemAddress4, 32'd5);
                if (AckA4) saw_ack = 1'b1;
            end else begin
                chk("l4_early_ack", {31'd0, saw_ack}, 32'd0);
                chk("l4_ack_c6", {31'd0, AckA4}, 32'd1);
                chk("l4_rdata", RDataA4, 32'hDEADBEEF);
            end
        end
        ReqA = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
